// File: rtl/wshb_if.sv
// Wishbone classic bus bundle shared by masters and the on-chip memory responder.
// Handshake: a request is valid while cyc & stb are high; the responder completes it with a one-cycle ack (or err) and the master holds we/adr/sel/dat_ms stable until then.
interface wshb_if (
    input logic clk,
    input logic rst
);
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_ms;
    logic [31:0] dat_sm;
    logic        ack;
    logic        err;

    modport master (
        input  clk, rst, dat_sm, ack, err,
        output cyc, stb, we, sel, adr, dat_ms
    );

    modport slave (
        input  clk, rst, cyc, stb, we, sel, adr, dat_ms,
        output dat_sm, ack, err
    );
endinterface

// File: rtl/wshb_mem_slave.sv
// Wishbone classic on-chip word memory with WAIT_STATES cycles of latency before ack.
// Define WSHB_MEM_ERR_EN to answer out-of-range addresses with err instead of aliasing.
module wshb_mem_slave #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 2
) (
    wshb_if.slave wshb_ifs
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [3:0]          wcnt;
    logic [3:0]          wcnt_nxt;
    logic [31:0]         mem [DEPTH];
    logic [31:0]         dat_q;
    logic [ADDR_W-1:0]   index;
    logic                req;
    logic                err_cond;
    logic                in_resp;
    logic                enter_resp;
    logic                ack_int;
    logic                wr_en;
    logic                unused_adr;

    assign req   = wshb_ifs.cyc & wshb_ifs.stb;
    assign index = wshb_ifs.adr[ADDR_W+1:2];

`ifdef WSHB_MEM_ERR_EN
    assign err_cond = |wshb_ifs.adr[31:ADDR_W+2];
`else
    assign err_cond = 1'b0;
`endif

    // Byte offset (and, without the error option, the upper bits) never select anything.
    assign unused_adr = ^{wshb_ifs.adr[1:0], wshb_ifs.adr[31:ADDR_W+2]};

    always_ff @(posedge wshb_ifs.clk) begin
        if (wshb_ifs.rst) begin
            state <= IDLE;
            wcnt  <= 4'd0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        case (state)
            IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        wcnt_nxt  = 4'(WAIT_STATES - 1);
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_nxt = IDLE;
                end else if (wcnt == 4'd0) begin
                    state_nxt = RESP;
                end else begin
                    wcnt_nxt = wcnt - 4'd1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign enter_resp = (state != RESP) && (state_nxt == RESP);

    // Read data is captured on entry to RESP so dat_sm never depends combinationally on adr.
    always_ff @(posedge wshb_ifs.clk) begin
        if (wshb_ifs.rst) begin
            dat_q <= 32'd0;
        end else if (enter_resp) begin
            dat_q <= err_cond ? 32'd0 : mem[index];
        end
    end

    // Gating with rst keeps a response that collides with reset from showing or writing.
    assign in_resp = (state == RESP) & ~wshb_ifs.rst;
    assign ack_int = in_resp & req & ~err_cond;
    assign wr_en   = ack_int & wshb_ifs.we;

    always_ff @(posedge wshb_ifs.clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wshb_ifs.sel[i]) begin
                    mem[index][8*i +: 8] <= wshb_ifs.dat_ms[8*i +: 8];
                end
            end
        end
    end

    assign wshb_ifs.dat_sm = dat_q;
    assign wshb_ifs.ack    = ack_int;

`ifdef WSHB_MEM_ERR_EN
    assign wshb_ifs.err = in_resp & req & err_cond;
`else
    assign wshb_ifs.err = 1'b0;
`endif
endmodule

// File: tb/tb_wshb_mem_slave.sv
// Directed bench for wshb_mem_slave: three instances with 2, 0 and 3 wait states on one clock/reset.
module tb_wshb_mem_slave;
    localparam int NDUT = 3;

`ifdef WSHB_MEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc    [NDUT];
    logic        stb    [NDUT];
    logic        we     [NDUT];
    logic [3:0]  sel    [NDUT];
    logic [31:0] adr    [NDUT];
    logic [31:0] dat_ms [NDUT];
    logic [31:0] dat_sm [NDUT];
    logic        ack    [NDUT];
    logic        err    [NDUT];

    logic [31:0] exp_q[$];
    int          vectors;
    int          miscompares;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int WS = (g == 0) ? 2 : (g == 1) ? 0 : 3;
        wshb_if bus (.clk(clk), .rst(rst));
        assign bus.cyc    = cyc[g];
        assign bus.stb    = stb[g];
        assign bus.we     = we[g];
        assign bus.sel    = sel[g];
        assign bus.adr    = adr[g];
        assign bus.dat_ms = dat_ms[g];
        assign dat_sm[g]  = bus.dat_sm;
        assign ack[g]     = bus.ack;
        assign err[g]     = bus.err;
        wshb_mem_slave #(.ADDR_W(10), .WAIT_STATES(WS)) u_dut (.wshb_ifs(bus.slave));
    end

    function automatic int ws_of(input int d);
        return (d == 0) ? 2 : (d == 1) ? 0 : 3;
    endfunction

    // ---------------- scoreboard check ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_all();
        for (int i = 0; i < NDUT; i++) begin
            cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
            sel[i] = 4'h0; adr[i] = 32'h0; dat_ms[i] = 32'h0;
        end
    endtask

    task automatic start_req(input int d, input logic w, input logic [31:0] a,
                             input logic [3:0] s, input logic [31:0] wd);
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w;
        adr[d] = a; sel[d] = s; dat_ms[d] = wd;
    endtask

    task automatic end_req(input int d);
        cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
    endtask

    // Waits (bounded) for ack or err; returns negedges counted since the request was driven.
    task automatic wait_resp(input int d, output int lat);
        logic got;
        got = 1'b0;
        lat = 0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (ack[d] || err[d]) got = 1'b1;
        end
    endtask

    // One complete transfer; read expectations go through exp_q.
    task automatic bus_xfer(input string tag, input int d, input logic w, input logic [31:0] a,
                            input logic [3:0] s, input logic [31:0] wd,
                            input logic exp_err, input logic [31:0] exp_rd);
        int lat;
        logic [31:0] rd;
        if (!w) exp_q.push_back(exp_rd);
        @(negedge clk);
        start_req(d, w, a, s, wd);
        wait_resp(d, lat);
        check({tag, "_lat"}, lat, ws_of(d) + 1);
        check({tag, "_ack"}, {31'd0, ack[d]}, {31'd0, ~exp_err});
        check({tag, "_err"}, {31'd0, err[d]}, {31'd0, exp_err});
        if (!w) begin
            rd = exp_q.pop_front();
            check({tag, "_dat"}, dat_sm[d], rd);
        end
        @(posedge clk);
        #1;
        end_req(d);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int lat;
        int nacks;
        int last;
        int cyc_i;
        int hits;
        logic [31:0] rd;

        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        idle_all();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("rst_ack%0d", i), {31'd0, ack[i]}, 32'd0);
            check($sformatf("rst_err%0d", i), {31'd0, err[i]}, 32'd0);
            check($sformatf("rst_dat%0d", i), dat_sm[i], 32'd0);
        end
        rst = 1'b0;

        // W=2 write then read back
        bus_xfer("w2_wr", 0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0);
        bus_xfer("w2_rd", 0, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 32'hDEADBEEF);

        // Byte-lane merge
        bus_xfer("bl_wr1", 0, 1'b1, 32'h30, 4'hF, 32'h11223344, 1'b0, 32'h0);
        bus_xfer("bl_wr2", 0, 1'b1, 32'h30, 4'b0101, 32'hAABBCCDD, 1'b0, 32'h0);
        bus_xfer("bl_rd", 0, 1'b0, 32'h30, 4'b0000, 32'h0, 1'b0, 32'h11BB33DD);

        // W=0 back-to-back reads with cyc/stb held high
        for (int i = 0; i < 4; i++) begin
            bus_xfer("b2b_fill", 1, 1'b1, 32'h100 + 32'(4 * i), 4'hF,
                     32'h01010101 * 32'(i + 1), 1'b0, 32'h0);
        end
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h01010101 * 32'(i + 1));
        @(negedge clk);
        start_req(1, 1'b0, 32'h100, 4'hF, 32'h0);
        nacks = 0;
        last  = 0;
        cyc_i = 0;
        while (nacks < 4 && cyc_i < 30) begin
            @(negedge clk);
            cyc_i++;
            if (ack[1]) begin
                rd = exp_q.pop_front();
                check("b2b_dat", dat_sm[1], rd);
                if (nacks > 0) check("b2b_gap", cyc_i - last, 32'd2);
                last = cyc_i;
                nacks++;
                @(posedge clk);
                #1;
                if (nacks == 4) end_req(1);
                else adr[1] = 32'h100 + 32'(4 * nacks);
            end
        end
        end_req(1);
        check("b2b_count", nacks, 32'd4);
        check("b2b_first", last - 2 * (nacks - 1), 32'd1);

        // W=3 aborted write leaves old word and no response
        bus_xfer("ab_wr", 2, 1'b1, 32'h40, 4'hF, 32'h12345678, 1'b0, 32'h0);
        @(negedge clk);
        start_req(2, 1'b1, 32'h40, 4'hF, 32'hFFFFFFFF);
        @(posedge clk);
        #1;
        stb[2] = 1'b0;
        hits = 0;
        repeat (8) begin
            @(negedge clk);
            if (ack[2] || err[2]) hits++;
        end
        end_req(2);
        check("ab_noresp", hits, 32'd0);
        bus_xfer("ab_rd", 2, 1'b0, 32'h40, 4'hF, 32'h0, 1'b0, 32'h12345678);

        // Reset during WAIT
        bus_xfer("rw_wr", 0, 1'b1, 32'h20, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0);
        bus_xfer("rw_rd0", 0, 1'b0, 32'h20, 4'hF, 32'h0, 1'b0, 32'hCAFEF00D);
        @(negedge clk);
        start_req(0, 1'b0, 32'h20, 4'hF, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        end_req(0);
        @(posedge clk);
        @(negedge clk);
        check("rw_ack", {31'd0, ack[0]}, 32'd0);
        check("rw_err", {31'd0, err[0]}, 32'd0);
        check("rw_dat", dat_sm[0], 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rw_post_ack", {31'd0, ack[0]}, 32'd0);
        bus_xfer("rw_rd1", 0, 1'b0, 32'h20, 4'hF, 32'h0, 1'b0, 32'hCAFEF00D);

        // Reset during RESP of a write: no ack, no write
        @(negedge clk);
        start_req(0, 1'b1, 32'h20, 4'hF, 32'h0BADBEEF);
        wait_resp(0, lat);
        check("rr_lat", lat, 32'd3);
        rst = 1'b1;
        #1;
        check("rr_ack", {31'd0, ack[0]}, 32'd0);
        @(posedge clk);
        #1;
        end_req(0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus_xfer("rr_rd", 0, 1'b0, 32'h20, 4'hF, 32'h0, 1'b0, 32'hCAFEF00D);

        // Out-of-range address: err with the option, aliasing to word 0 without it
        bus_xfer("oor_w0", 0, 1'b1, 32'h0, 4'hF, 32'h5A5A5A5A, 1'b0, 32'h0);
        bus_xfer("oor_wr", 0, 1'b1, 32'h1000, 4'hF, 32'h77777777, ERR_EN, 32'h0);
        bus_xfer("oor_rd", 0, 1'b0, 32'h1000, 4'hF, 32'h0, ERR_EN,
                 ERR_EN ? 32'h0 : 32'h77777777);
        bus_xfer("oor_w0rd", 0, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0,
                 ERR_EN ? 32'h5A5A5A5A : 32'h77777777);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
